// File: rtl/conv_enc_k5_framer.sv
// Rate-1/2, K=5 convolutional encoder with framing.
// Serial data bits are grouped into FRAME_LEN-bit frames. Each frame is
// followed by K-1 zero tail bits, so the trellis ends in state 0. One 2-bit
// symbol is produced per data or tail bit through a back-pressurable output
// register.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. This holds for encoder_i (enable_encoder_i/enc_ready_o) and for
// sym_o (sym_valid_o/sym_ready_i). While valid is high and ready is low, the
// producer holds its data and its flags stable. enc_ready_o depends
// combinationally on sym_ready_i. It never depends on enable_encoder_i.
module conv_enc_k5_framer #(
  parameter int             K         = 5,
  parameter logic [K-1:0]   G0        = 5'b10011,
  parameter logic [K-1:0]   G1        = 5'b11101,
  parameter int             FRAME_LEN = 256,
  parameter int             CT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            encoder_i,
  input  logic            enable_encoder_i,
  output logic            enc_ready_o,
  output logic [1:0]      sym_o,
  output logic            sym_valid_o,
  input  logic            sym_ready_i,
  output logic            frame_start_o,
  output logic            frame_end_o,
  output logic [CT_W-1:0] bit_ct,
  output logic [CT_W-1:0] frame_ct
);

  localparam int SW = K - 1;
  localparam int TW = (SW > 1) ? $clog2(SW) : 1;
  localparam logic [TW-1:0]   TAIL_LAST = TW'(SW - 1);
  localparam logic [CT_W-1:0] FLEN      = CT_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [SW-1:0]   s;          // s[0] is the most recent previous bit
  logic [TW-1:0]   tail_ct;
  logic [CT_W-1:0] bit_nx;
  logic            load_ok;
  logic            xfer;
  logic            tail_step;
  logic            tail_last;
  logic            load;
  logic            bit_in;
  logic [K-1:0]    v;
  logic            c0;
  logic            c1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state, input readiness and the source of the next bit
  always_comb begin
    state_nx    = state;
    enc_ready_o = 1'b0;
    xfer        = 1'b0;
    tail_step   = 1'b0;
    tail_last   = 1'b0;
    bit_in      = 1'b0;
    load_ok     = !sym_valid_o || sym_ready_i;
    bit_nx      = (state == IDLE) ? CT_W'(1) : bit_ct + 1'b1;
    case (state)
      IDLE, DATA: begin
        // Held low during reset even though the registers already read IDLE
        enc_ready_o = rst && load_ok;
        xfer        = enable_encoder_i && enc_ready_o;
        bit_in      = encoder_i;
        if (xfer) begin
          if (bit_nx == FLEN) state_nx = TAIL;
          else                state_nx = DATA;
        end
      end
      TAIL: begin
        // Tail bits are zero; one is consumed per output-register load
        tail_step = load_ok;
        tail_last = tail_step && (tail_ct == TAIL_LAST);
        if (tail_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Generator input vector: current bit on top, oldest history bit at index 0
  always_comb begin
    v = '0;
    v[K-1] = bit_in;
    for (int i = 0; i < SW; i++) begin
      v[SW-1-i] = s[i];
    end
  end

  assign c0   = ^(v & G0);
  assign c1   = ^(v & G1);
  assign load = xfer || tail_step;

  // Output register with flags, plus the encoder shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s             <= '0;
      sym_o         <= 2'b00;
      sym_valid_o   <= 1'b0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
    end else if (load) begin
      s             <= {s[SW-2:0], bit_in};
      sym_o         <= {c0, c1};
      sym_valid_o   <= 1'b1;
      frame_start_o <= xfer && (state == IDLE);
      frame_end_o   <= tail_last;
    end else if (sym_ready_i) begin
      sym_valid_o   <= 1'b0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
    end
  end

  // Bit, tail and frame counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_ct   <= '0;
      frame_ct <= '0;
      tail_ct  <= '0;
    end else begin
      if (xfer) bit_ct <= bit_nx;
      if (tail_step) begin
        if (tail_last) tail_ct <= '0;
        else           tail_ct <= tail_ct + 1'b1;
      end
      if (tail_last) begin
        bit_ct   <= '0;
        frame_ct <= frame_ct + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_enc_k5_framer.sv
// Bench for conv_enc_k5_framer: an impulse table (FRAME_LEN=1), a frame
// counter wrap table (FRAME_LEN=2, CT_W=2), and full 256-bit frames against a
// reference encoder. The full-frame runs cover backpressure, idle gaps and a
// reset in the middle of a frame.
module tb_conv_enc_k5_framer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT: FRAME_LEN=1 ----------------
  logic d1 = 1'b0, en1 = 1'b0, rdy1, v1, fs1, fe1;
  logic [1:0]  sym1;
  logic [15:0] bct1, fct1;
  conv_enc_k5_framer #(.FRAME_LEN(1)) u1 (
    .clk(clk), .rst(rst), .encoder_i(d1), .enable_encoder_i(en1),
    .enc_ready_o(rdy1), .sym_o(sym1), .sym_valid_o(v1), .sym_ready_i(1'b1),
    .frame_start_o(fs1), .frame_end_o(fe1), .bit_ct(bct1), .frame_ct(fct1));

  // ---------------- DUT: FRAME_LEN=2, CT_W=2 ----------------
  logic d2 = 1'b0, en2 = 1'b0, rdy2, v2, fs2, fe2;
  logic [1:0] sym2, bct2, fct2;
  conv_enc_k5_framer #(.FRAME_LEN(2), .CT_W(2)) u2 (
    .clk(clk), .rst(rst), .encoder_i(d2), .enable_encoder_i(en2),
    .enc_ready_o(rdy2), .sym_o(sym2), .sym_valid_o(v2), .sym_ready_i(1'b1),
    .frame_start_o(fs2), .frame_end_o(fe2), .bit_ct(bct2), .frame_ct(fct2));

  // ---------------- DUT: FRAME_LEN=256 ----------------
  logic m_d = 1'b0, m_en = 1'b0, m_ready = 1'b1, m_rdy, m_valid, m_fs, m_fe;
  logic [1:0]  m_sym;
  logic [15:0] m_bct, m_fct;
  conv_enc_k5_framer u256 (
    .clk(clk), .rst(rst), .encoder_i(m_d), .enable_encoder_i(m_en),
    .enc_ready_o(m_rdy), .sym_o(m_sym), .sym_valid_o(m_valid),
    .sym_ready_i(m_ready), .frame_start_o(m_fs), .frame_end_o(m_fe),
    .bit_ct(m_bct), .frame_ct(m_fct));

  // ---------------- tables ----------------
  typedef struct {
    logic [1:0]  sym;
    logic        fs;
    logic        fe;
    logic        rdy;
    logic [15:0] fct;
  } imp_t;
  imp_t imp[5];

  typedef struct {
    logic [1:0]  bits;   // {first bit, second bit}
    logic [11:0] syms;   // six symbols, first in the top two bits
    logic [1:0]  fct;
  } wrap_t;
  wrap_t wt[5];

  // ---------------- scoreboard state ----------------
  logic [3:0] exp_q[$];  // {frame_start, frame_end, sym}
  logic [3:0] e;
  logic       frame_bits[256];
  logic [7:0] pat;
  int         m_syms  = 0;
  int         rdy_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: taps octal 23 -> {cur, d3, d4}, octal 35 -> {cur, d1, d2, d4}
  task automatic push_frame_exp();
    logic [4:1] h;
    logic b, c0, c1;
    h = '0;
    for (int i = 0; i < 260; i++) begin
      b  = (i < 256) ? frame_bits[i] : 1'b0;
      c0 = b ^ h[3] ^ h[4];
      c1 = b ^ h[1] ^ h[2] ^ h[4];
      exp_q.push_back({(i == 0), (i == 259), c0, c1});
      h = {h[3:1], b};
    end
  endtask

  // Drive one bit into u256; entered and left at posedge+1
  task automatic send_bit(input logic b, input bit gaps);
    bit ok;
    if (gaps) begin
      m_en = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    m_en = 1'b1;
    m_d  = b;
    ok   = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      if (m_rdy) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_bit: enc_ready_o stuck 0 for 64 clks at %0t", $time);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- monitor for u256 ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (!m_rdy) rdy_low++;
      if (m_valid && m_ready) begin
        m_syms++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sym_extra: got %0h with nothing expected at %0t", {m_fs, m_fe, m_sym}, $time);
        end else begin
          e = exp_q.pop_front();
          check("sym", {28'd0, m_fs, m_fe, m_sym}, {28'd0, e});
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0] snap;
    wrap_t w;

    imp[0] = '{2'b11, 1'b1, 1'b0, 1'b0, 16'd0};
    imp[1] = '{2'b01, 1'b0, 1'b0, 1'b0, 16'd0};
    imp[2] = '{2'b01, 1'b0, 1'b0, 1'b0, 16'd0};
    imp[3] = '{2'b10, 1'b0, 1'b0, 1'b0, 16'd0};
    imp[4] = '{2'b11, 1'b0, 1'b1, 1'b1, 16'd1};

    wt[0] = '{2'b10, 12'b11_01_01_10_11_00, 2'd1};
    wt[1] = '{2'b01, 12'b00_11_01_01_10_11, 2'd2};
    wt[2] = '{2'b11, 12'b11_10_00_11_01_11, 2'd3};
    wt[3] = '{2'b00, 12'b00_00_00_00_00_00, 2'd0};
    wt[4] = '{2'b10, 12'b11_01_01_10_11_00, 2'd1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sym",   m_sym,   2'b00);
    check("rst_valid", m_valid, 1'b0);
    check("rst_fs",    m_fs,    1'b0);
    check("rst_fe",    m_fe,    1'b0);
    check("rst_bct",   m_bct,   16'd0);
    check("rst_fct",   m_fct,   16'd0);
    check("rst_rdy",   m_rdy,   1'b0);
    check("rst_rdy1",  rdy1,    1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_rdy", m_rdy, 1'b1);

    // impulse with FRAME_LEN=1
    @(posedge clk); #1;
    en1 = 1'b1;
    d1  = 1'b1;
    @(negedge clk);
    check("imp_rdy_idle", rdy1, 1'b1);
    @(posedge clk); #1;
    en1 = 1'b0;
    d1  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("imp_valid", v1,   1'b1);
      check("imp_sym",   sym1, imp[i].sym);
      check("imp_fs",    fs1,  imp[i].fs);
      check("imp_fe",    fe1,  imp[i].fe);
      check("imp_rdy",   rdy1, imp[i].rdy);
      check("imp_fct",   fct1, imp[i].fct);
    end
    @(negedge clk);
    check("imp_drop", v1, 1'b0);

    // frame counter wrap with FRAME_LEN=2, CT_W=2
    for (int f = 0; f < 5; f++) begin
      w = wt[f];
      @(posedge clk); #1;
      en2 = 1'b1;
      d2  = w.bits[1];
      @(negedge clk);
      check("wrap_rdy", rdy2, 1'b1);
      @(posedge clk); #1;
      d2 = w.bits[0];
      @(negedge clk);
      check("wrap_sym0", {v2, fs2, fe2, sym2}, {3'b110, w.syms[11:10]});
      @(posedge clk); #1;
      en2 = 1'b0;
      for (int k = 1; k < 6; k++) begin
        if (k > 1) @(negedge clk);
        else       @(negedge clk);
        check("wrap_sym", {v2, fs2, fe2, sym2}, {1'b1, 1'b0, (k == 5), w.syms[11-2*k -: 2]});
      end
      check("wrap_fct", fct2, w.fct);
    end

    // full frame, continuous, repeating pattern
    pat = 8'b10011011;
    for (int i = 0; i < 256; i++) frame_bits[i] = pat[7 - (i % 8)];
    @(posedge clk); #1;
    m_syms  = 0;
    rdy_low = 0;
    push_frame_exp();
    for (int i = 0; i < 256; i++) send_bit(frame_bits[i], 1'b0);
    m_en = 1'b0;
    drain("t2_drain");
    check("t2_count",   m_syms,  260);
    check("t2_fct",     m_fct,   16'd1);
    check("t2_bct",     m_bct,   16'd0);
    check("t2_rdy_low", rdy_low, 4);

    // backpressure for 3 clks mid-frame
    for (int i = 0; i < 256; i++) frame_bits[i] = 1'($urandom_range(0, 1));
    m_syms = 0;
    push_frame_exp();
    fork
      begin
        for (int i = 0; i < 256; i++) send_bit(frame_bits[i], 1'b0);
        m_en = 1'b0;
      end
      begin
        repeat (120) @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        snap = {m_valid, m_fs, m_fe, m_sym};
        check("bp_valid", m_valid, 1'b1);
        check("bp_rdy0",  m_rdy,   1'b0);
        for (int k = 1; k < 3; k++) begin
          @(negedge clk);
          check("bp_hold", {m_valid, m_fs, m_fe, m_sym}, snap);
          check("bp_rdy",  m_rdy, 1'b0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_hold3", {m_valid, m_fs, m_fe, m_sym}, snap);
      end
    join
    drain("t3_drain");
    check("t3_count", m_syms, 260);
    check("t3_fct",   m_fct,  16'd2);

    // two frames with random idle gaps
    m_syms = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 256; i++) frame_bits[i] = 1'($urandom_range(0, 1));
      push_frame_exp();
      for (int i = 0; i < 256; i++) send_bit(frame_bits[i], 1'b1);
      m_en = 1'b0;
    end
    drain("t4_drain");
    check("t4_count", m_syms, 520);
    check("t4_fct",   m_fct,  16'd4);

    // reset after 100 bits of a frame
    for (int i = 0; i < 256; i++) frame_bits[i] = 1'($urandom_range(0, 1));
    push_frame_exp();
    for (int i = 0; i < 100; i++) send_bit(frame_bits[i], 1'b0);
    m_en = 1'b0;
    check("t5_bct100", m_bct, 16'd100);
    #1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("t5_sym",   m_sym,   2'b00);
    check("t5_valid", m_valid, 1'b0);
    check("t5_fs",    m_fs,    1'b0);
    check("t5_fe",    m_fe,    1'b0);
    check("t5_bct",   m_bct,   16'd0);
    check("t5_fct",   m_fct,   16'd0);
    check("t5_rdy",   m_rdy,   1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    m_syms = 0;
    for (int i = 0; i < 256; i++) frame_bits[i] = 1'($urandom_range(0, 1));
    frame_bits[0] = 1'b1;
    push_frame_exp();
    send_bit(frame_bits[0], 1'b0);
    check("t5_first", {m_valid, m_fs, m_fe, m_sym}, 5'b1_1_0_11);
    for (int i = 1; i < 256; i++) send_bit(frame_bits[i], 1'b0);
    m_en = 1'b0;
    drain("t5_drain");
    check("t5_count",    m_syms, 260);
    check("t5_fct_after", m_fct, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_enc_k5_framer.md
Name: conv_enc_k5_framer

Overview:
Transmit-side rate-1/2 convolutional encoder (constraint length K=5) that feeds the channel/Viterbi-decoder path.
- Accepts serial data bits under a valid/ready handshake and groups them into frames of FRAME_LEN bits.
- Appends K-1 zero tail bits after each frame so the decoder sees the trellis terminated in state 0.
- Emits one 2-bit code symbol per accepted or tail bit through a registered, back-pressurable output.

Parameters:
K, 5, constraint length; the encoder state register is K-1 bits.
G0, 5'b10011, generator polynomial for symbol bit 1 (octal 23); bit K-1 taps the current input.
G1, 5'b11101, generator polynomial for symbol bit 0 (octal 35).
FRAME_LEN, 256, number of data bits per frame, legal range 1..65535.
CT_W, 16, width of the bit counter and the frame counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
encoder_i  input  1  data bit to encode
enable_encoder_i  input  1  data valid; the bit transfers on a clk edge where enable_encoder_i && enc_ready_o
enc_ready_o  output  1  encoder can accept a data bit this cycle
sym_o  output  2  code symbol {c0,c1}, held stable while sym_valid_o=1 and sym_ready_i=0
sym_valid_o  output  1  sym_o holds a valid symbol
sym_ready_i  input  1  downstream accepts sym_o on a clk edge where sym_valid_o && sym_ready_i
frame_start_o  output  1  qualifies the symbol of the first data bit of a frame
frame_end_o  output  1  qualifies the symbol of the last tail bit of a frame
bit_ct  output  CT_W  data bits accepted in the current frame
frame_ct  output  CT_W  completed frames, wraps modulo 2^CT_W

Behaviour:
- Reset (rst=0, asynchronous), all outputs and state cleared:
  - state IDLE, shift register s=0, bit_ct=0, frame_ct=0
  - sym_o=2'b00, sym_valid_o=0, frame_start_o=0, frame_end_o=0
  - enc_ready_o=0 while rst=0
- Reset asserted mid-frame discards the partial frame. No tail is emitted. The next frame starts from s=0.
- Encoding:
  - v = {b, s[0], s[1], ..., s[K-2]}; v[K-1]=b is the current bit, s[0] is the most recent previous bit.
  - c0 = ^(v & G0), c1 = ^(v & G1).
  - Shift update: s <= {s[K-3:0], b}.
- Output register:
  - Loaded when (!sym_valid_o || sym_ready_i) and a bit is available (data transfer or tail step).
  - Latency: 1 clk from data transfer to sym_valid_o.
  - Full throughput of one symbol per clk when sym_ready_i=1.
  - sym_valid_o drops when the symbol is consumed and no new bit is loaded.
- Ready: enc_ready_o = (state==IDLE || state==DATA) && (!sym_valid_o || sym_ready_i). This is combinational from sym_ready_i. There is no path from enable_encoder_i to enc_ready_o.
- FSM:
  - IDLE:
    - On transfer: encode the bit, bit_ct<=1, frame_start_o=1 with that symbol.
    - Then go to DATA, or to TAIL if FRAME_LEN==1.
  - DATA:
    - Each transfer increments bit_ct.
    - On the transfer that makes bit_ct==FRAME_LEN, go to TAIL.
    - enable_encoder_i low stalls the frame indefinitely. No flush occurs and state is retained.
  - TAIL:
    - enc_ready_o=0.
    - Encode b=0 on each output-register load, K-1 loads total, tracked by a tail counter.
    - On the last load: frame_end_o=1, frame_ct++, bit_ct<=0, go to IDLE.
    - After the tail, s is all-zero by construction.
- frame_start_o and frame_end_o are registered with sym_o and held with it under backpressure.
- With FRAME_LEN=1, frame_start_o and frame_end_o mark different symbols.
- Simultaneous consume and load in one clk is legal: the output register updates with no bubble.
- bit_ct saturates logic is not needed because FRAME_LEN < 2^CT_W.

Test Plan:
- Impulse, FRAME_LEN=1, sym_ready_i=1, send one bit 1 -> sym_o sequence 11,01,01,10,11 on 5 consecutive clks. frame_start_o is set on the 1st symbol, frame_end_o on the 5th, frame_ct=1, then IDLE with enc_ready_o=1.
- FRAME_LEN=256, continuous enable with the pattern 1,0,0,1,1,0,1,1 repeated, sym_ready_i=1 -> exactly 260 symbols and frame_ct=1. Symbols match a reference-model encoder. enc_ready_o is 0 for exactly 4 clks during the tail.
- Backpressure: drop sym_ready_i for 3 clks mid-frame -> sym_o, sym_valid_o and flags are stable for 3 clks, enc_ready_o=0, no bits lost or duplicated, and the symbol count is still FRAME_LEN+4.
- Idle gaps: toggle enable_encoder_i randomly over 2 frames -> output equals the gap-free stream, and frame_ct=2.
- Reset mid-frame: assert rst after 100 bits -> all outputs are 0 immediately (asynchronous). A new frame's first bit 1 then yields symbol 11, proving s=0.
- Wrap: CT_W=2, run 5 frames with FRAME_LEN=2 -> frame_ct sequence 1,2,3,0,1.
